checker_ctlif_mc: RTL
=====================

# checker_ctlif_mc

Multi-channel control interface for the checker cores. It exposes `NCHAN` independent checker channels behind one CSR slot. Each channel has its own address, mode, start/stop, event and interrupt-ack handshake, plus a per-channel run watchdog and elapsed-cycle counter. It sits between the LM32 CSR bus and up to eight checker mode engines, and drives one aggregated LM32 IRQ line.

## Interface
- `csr_addr`, default 4'h0: CSR slot matched against `csr_a[13:10]`.
- `NCHAN`, default 2: number of channels, legal range 1..8.
- `sys_clk`  in  1: system clock; all logic is on its rising edge.
- `sys_rst_n`  in  1: reset, asynchronous and active-low.
- `csr_a`  in  14: CSR address.
  - `[13:10]` is the slot.
  - `[9]` selects the global bank.
  - `[5:3]` is the channel.
  - `[2:0]` is the register.
- `csr_we`  in  1: CSR write strobe.
- `csr_di`  in  32: CSR write data.
- `csr_do`  out  32: CSR read data, registered.
- `mode_mode`  out  2*NCHAN: per-channel mode; channel i occupies `[2i+1:2i]`.
- `mode_start`  out  NCHAN: per-channel run request.
- `mode_addr`  out  64*NCHAN: per-channel page address.
- `mode_end`  in  NCHAN: channel finished.
- `mode_error`  in  NCHAN: channel failed.
- `mode_irq`  in  NCHAN: channel requests service.
- `mode_ack`  out  NCHAN: one-cycle service acknowledge.
- `mode_data`  in  64*NCHAN: per-channel status data.
- `irq`  out  1: OR over channels of `irq_en & (end | error | mode_irq | timeout)`.

## Operation
- Per-channel registers, selected by `csr_a[2:0]`:
  - 0 ADDR_LOW, 1 ADDR_HIGH: RW, writable only in IDLE.
  - 2 STAT:
    - bit0 end, bit1 error, bit2 mode_irq, bit3 timeout: write-one-to-clear, honoured only in IDLE or WAIT.
    - bits[5:4] state: read-only.
  - 3 CTRL:
    - bit0 irq_en and bits[2:1] mode: writable only in IDLE.
    - bit3 start: writable in any state.
  - 4 DATA_LOW, 5 DATA_HIGH: read-only `mode_data` halves.
  - 6 TIMEOUT: 32-bit watchdog reload, writable only in IDLE; 0 disables the watchdog.
  - 7 ELAPSED: read-only, 32-bit, saturating.
- Global bank (`csr_a[9]=1`):
  - reg 0 PENDING: read-only; bit i = channel i irq contribution.
  - reg 1 INFO: read-only, `{24'b0, NCHAN[7:0]}`.
- Reads of a channel index ≥ NCHAN, or of an unmapped register, return 0; writes to them are ignored.
- Per-channel FSM, encodings in the shared header (IDLE=0, RUN=1, WAIT=2, ACK=3):
  - IDLE, CTRL write with start=1 → RUN:
    - `mode_start` rises.
    - ELAPSED clears.
    - Watchdog loads TIMEOUT.
  - RUN, evaluated in priority order:
    1. `mode_end` → IDLE, start=0, end event set.
    2. else `mode_error` → IDLE, start=0, error event set.
    3. else watchdog enabled and count==1 → IDLE, start=0, timeout event set.
    4. else `mode_irq` → WAIT, mode_irq event set.
    5. else CTRL write with start=0 → IDLE, start=0, no event (abort).
  - WAIT:
    - mode_irq event cleared → ACK.
    - else `mode_start`=0 (written by CSR) → IDLE, mode_irq event cleared.
  - ACK: `mode_ack`=1 for exactly this cycle, then → RUN.
- Writing start=1 outside IDLE has no effect.
- Watchdog: decrements each RUN cycle; frozen in WAIT and ACK.
- ELAPSED: increments in RUN/WAIT/ACK; holds in IDLE; saturates at 32'hFFFFFFFF.
- A hardware event set and a CSR clear of the same bit in the same cycle: set wins.

## Timing
- Reset values:
  - `csr_do`=0, `mode_start`=0, `mode_ack`=0, `mode_addr`=0.
  - `mode_mode`=CHECKER_MODE_SINGLE.
  - All events, irq_en, TIMEOUT and ELAPSED are 0.
  - State is IDLE.
  - `irq`=0.
- `csr_do`: valid one cycle after the address is presented; 0 when the slot is not selected.
- CSR write at cycle N:
  - Register values are visible at N+1.
  - A start write gives `mode_start`=1 and state RUN at N+1.
- `mode_end` sampled at cycle N: `mode_start`=0, state IDLE, STAT.end=1 and `irq` (if enabled) at N+1.
- Service handshake, with the mode_irq event cleared at cycle N: ACK at N+1, `mode_ack` high for N+1 only, RUN at N+2.
- With TIMEOUT=T and no end/error/irq, the timeout event is set T cycles after RUN entry.
- Channels are fully independent. Simultaneous events on different channels are all captured in the same cycle.
- Asserting reset mid-run clears everything immediately (asynchronously), including dropping `mode_start`.

## Structure
- `checker.vh` gains the following:
  - Existing CSR indexes plus CHECKER_CSR_TIMEOUT=6 and CHECKER_CSR_ELAPSED=7.
  - Global indexes CHECKER_GCSR_PENDING=0 and CHECKER_GCSR_INFO=1.
  - State encodings, including the new WAIT/ACK names.
  - Mode encodings.
  - STAT bit positions.
- Sub-module `checker_ctlif_chan`: one channel's registers, FSM, watchdog and ELAPSED counter. The top level instantiates it with a generate loop and adds only CSR decode, the read mux and the IRQ OR.

## Test plan
- Reset, then read every register of channel 0 and of the global bank:
  - All read 0, except INFO = NCHAN (2).
  - `mode_mode`=SINGLE.
- Channel 1:
  - Write ADDR_LOW=32'h1000, CTRL=4'b1001.
  - Pulse `mode_end` at cycle 20.
  - Expect: start high cycles 1..20, low at 21; STAT=1; `irq`=1; PENDING=2'b10; ELAPSED=20.
- Channel 0 service cycle:
  - Pulse `mode_irq` → STAT bit2 set, state WAIT.
  - Write STAT=4 → `mode_ack` one-cycle pulse, then RUN.
  - Watchdog count is unchanged across WAIT.
- Channel 0 watchdog:
  - TIMEOUT=5, start, no response.
  - Expect: timeout event at cycle 5 after start, start=0, STAT=8.
- Concurrency and locking:
  - `mode_end` on both channels in the same cycle → both end bits set.
  - An ADDR write during RUN is ignored.
  - Writing start=0 during RUN aborts with STAT=0.
- Reset mid-operation and out-of-range access:
  - Deassert `sys_rst_n` mid-RUN → all outputs 0 asynchronously.
  - Read of channel index 5 with NCHAN=2 returns 0.

Source files
------------

// File: rtl/checker_ctlif_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : checker_ctlif_mc_pkg
// Description : Shared definitions for the multi-channel checker control
//               interface: CSR register indexes (per-channel and global
//               bank), channel state encodings, checker mode encodings and
//               STAT/CTRL bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package checker_ctlif_mc_pkg;

  // Per-channel register indexes (csr_a[2:0])
  localparam logic [2:0] CHECKER_CSR_ADDR_LOW  = 3'd0;
  localparam logic [2:0] CHECKER_CSR_ADDR_HIGH = 3'd1;
  localparam logic [2:0] CHECKER_CSR_STAT      = 3'd2;
  localparam logic [2:0] CHECKER_CSR_CTRL      = 3'd3;
  localparam logic [2:0] CHECKER_CSR_DATA_LOW  = 3'd4;
  localparam logic [2:0] CHECKER_CSR_DATA_HIGH = 3'd5;
  localparam logic [2:0] CHECKER_CSR_TIMEOUT   = 3'd6;
  localparam logic [2:0] CHECKER_CSR_ELAPSED   = 3'd7;

  // Global bank register indexes (csr_a[9] = 1)
  localparam logic [2:0] CHECKER_GCSR_PENDING  = 3'd0;
  localparam logic [2:0] CHECKER_GCSR_INFO     = 3'd1;

  // Channel state encodings
  typedef enum logic [1:0] {
    CHECKER_STATE_IDLE = 2'd0,
    CHECKER_STATE_RUN  = 2'd1,
    CHECKER_STATE_WAIT = 2'd2,
    CHECKER_STATE_ACK  = 2'd3
  } checker_state_e;

  // Checker mode encodings
  localparam logic [1:0] CHECKER_MODE_SINGLE = 2'd0;
  localparam logic [1:0] CHECKER_MODE_LOOP   = 2'd1;
  localparam logic [1:0] CHECKER_MODE_RANDOM = 2'd2;
  localparam logic [1:0] CHECKER_MODE_FULL   = 2'd3;

  // STAT bit positions
  localparam int CHECKER_STAT_END       = 0;
  localparam int CHECKER_STAT_ERROR     = 1;
  localparam int CHECKER_STAT_IRQ       = 2;
  localparam int CHECKER_STAT_TIMEOUT   = 3;
  localparam int CHECKER_STAT_STATE_LSB = 4;

  // CTRL bit positions
  localparam int CHECKER_CTRL_IRQ_EN   = 0;
  localparam int CHECKER_CTRL_MODE_LSB = 1;
  localparam int CHECKER_CTRL_START    = 3;

endpackage : checker_ctlif_mc_pkg
`default_nettype wire

// File: rtl/checker_ctlif_chan.sv
`default_nettype none
// ============================================================================
// Module      : checker_ctlif_chan
// Description : One checker channel: address/ctrl/timeout registers, event
//               flags, IDLE/RUN/WAIT/ACK handshake FSM, run watchdog and a
//               saturating elapsed-cycle counter.
// Ports       : clk, rst_n         - clock, async active-low reset
//               we, reg_sel, wdata - decoded CSR write for this channel
//               hw_end/error/irq   - engine status inputs
//               status_data        - engine status data (read-only regs)
//               rdata              - combinational register read value
//               mode, start, addr  - engine control outputs
//               ack                - one-cycle service acknowledge
//               irq_req            - irq_en & any event
// Revision    : 1.0 - initial release
// ============================================================================
module checker_ctlif_chan
  import checker_ctlif_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [2:0]  reg_sel,
  input  logic [31:0] wdata,
  input  logic        hw_end,
  input  logic        hw_error,
  input  logic        hw_irq,
  input  logic [63:0] status_data,
  output logic [31:0] rdata,
  output logic [1:0]  mode,
  output logic        start,
  output logic [63:0] addr,
  output logic        ack,
  output logic        irq_req
);

  checker_state_e state, state_nx;
  logic [3:0]     events, events_set, events_clr, events_nx;
  logic           irq_en;
  logic [31:0]    timeout, wd_count, elapsed;
  logic           wr_ctrl, wr_stat, is_idle, load_run, wd_fire;

  assign is_idle = (state == CHECKER_STATE_IDLE);
  assign wr_ctrl = we && (reg_sel == CHECKER_CSR_CTRL);
  assign wr_stat = we && (reg_sel == CHECKER_CSR_STAT);
  // A TIMEOUT of zero disables the watchdog entirely.
  assign wd_fire = (timeout != 32'd0) && (wd_count == 32'd1);

  always_comb begin
    state_nx   = state;
    events_set = 4'b0000;
    events_clr = 4'b0000;
    load_run   = 1'b0;
    // Software clears are only honoured while the engine is not running.
    if (wr_stat && (state == CHECKER_STATE_IDLE || state == CHECKER_STATE_WAIT))
      events_clr = wdata[3:0];
    case (state)
      CHECKER_STATE_IDLE: begin
        if (wr_ctrl && wdata[CHECKER_CTRL_START]) begin
          state_nx = CHECKER_STATE_RUN;
          load_run = 1'b1;
        end
      end
      CHECKER_STATE_RUN: begin
        if (hw_end) begin
          state_nx = CHECKER_STATE_IDLE;
          events_set[CHECKER_STAT_END] = 1'b1;
        end else if (hw_error) begin
          state_nx = CHECKER_STATE_IDLE;
          events_set[CHECKER_STAT_ERROR] = 1'b1;
        end else if (wd_fire) begin
          state_nx = CHECKER_STATE_IDLE;
          events_set[CHECKER_STAT_TIMEOUT] = 1'b1;
        end else if (hw_irq) begin
          state_nx = CHECKER_STATE_WAIT;
          events_set[CHECKER_STAT_IRQ] = 1'b1;
        end else if (wr_ctrl && !wdata[CHECKER_CTRL_START]) begin
          state_nx = CHECKER_STATE_IDLE;
        end
      end
      CHECKER_STATE_WAIT: begin
        // Clearing the irq event (now or earlier) acknowledges the service.
        if (!events[CHECKER_STAT_IRQ] || events_clr[CHECKER_STAT_IRQ]) begin
          state_nx = CHECKER_STATE_ACK;
        end else if (wr_ctrl && !wdata[CHECKER_CTRL_START]) begin
          state_nx = CHECKER_STATE_IDLE;
          events_clr[CHECKER_STAT_IRQ] = 1'b1;
        end
      end
      CHECKER_STATE_ACK: begin
        // A stop written during the ack cycle returns straight to IDLE.
        if (wr_ctrl && !wdata[CHECKER_CTRL_START])
          state_nx = CHECKER_STATE_IDLE;
        else
          state_nx = CHECKER_STATE_RUN;
      end
      default: state_nx = CHECKER_STATE_IDLE;
    endcase
    // Hardware set takes precedence over a same-cycle software clear.
    events_nx = (events & ~events_clr) | events_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CHECKER_STATE_IDLE;
      events   <= 4'b0000;
      irq_en   <= 1'b0;
      mode     <= CHECKER_MODE_SINGLE;
      addr     <= 64'd0;
      timeout  <= 32'd0;
      wd_count <= 32'd0;
      elapsed  <= 32'd0;
    end else begin
      state  <= state_nx;
      events <= events_nx;
      if (we && is_idle) begin
        case (reg_sel)
          CHECKER_CSR_ADDR_LOW:  addr[31:0]  <= wdata;
          CHECKER_CSR_ADDR_HIGH: addr[63:32] <= wdata;
          CHECKER_CSR_CTRL: begin
            irq_en <= wdata[CHECKER_CTRL_IRQ_EN];
            mode   <= wdata[CHECKER_CTRL_MODE_LSB +: 2];
          end
          CHECKER_CSR_TIMEOUT:   timeout     <= wdata;
          default: ;
        endcase
      end
      // Watchdog only counts RUN cycles; it is frozen in WAIT and ACK.
      if (load_run)
        wd_count <= timeout;
      else if (state == CHECKER_STATE_RUN && wd_count != 32'd0)
        wd_count <= wd_count - 32'd1;
      if (load_run)
        elapsed <= 32'd0;
      else if (!is_idle && elapsed != 32'hFFFF_FFFF)
        elapsed <= elapsed + 32'd1;
    end
  end

  // The run request is exactly "not idle": every exit path to IDLE drops it.
  assign start   = !is_idle;
  assign ack     = (state == CHECKER_STATE_ACK);
  assign irq_req = irq_en && (events != 4'b0000);

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      CHECKER_CSR_ADDR_LOW:  rdata = addr[31:0];
      CHECKER_CSR_ADDR_HIGH: rdata = addr[63:32];
      CHECKER_CSR_STAT:      rdata = {26'd0, state, events};
      CHECKER_CSR_CTRL:      rdata = {28'd0, start, mode, irq_en};
      CHECKER_CSR_DATA_LOW:  rdata = status_data[31:0];
      CHECKER_CSR_DATA_HIGH: rdata = status_data[63:32];
      CHECKER_CSR_TIMEOUT:   rdata = timeout;
      CHECKER_CSR_ELAPSED:   rdata = elapsed;
      default:               rdata = 32'd0;
    endcase
  end

endmodule : checker_ctlif_chan
`default_nettype wire

// File: rtl/checker_ctlif_mc.sv
`default_nettype none
// ============================================================================
// Module      : checker_ctlif_mc
// Description : Multi-channel checker control interface. NCHAN (1..8)
//               independent channels behind one CSR slot, plus a global bank
//               (PENDING, INFO) and one aggregated IRQ line.
// Ports       : sys_clk, sys_rst_n      - clock, async active-low reset
//               csr_a/csr_we/csr_di     - CSR bus in; csr_do registered out
//               mode_mode/start/addr    - per-channel engine controls
//               mode_end/error/irq      - per-channel engine status
//               mode_ack                - per-channel service acknowledge
//               mode_data               - per-channel status data
//               irq                     - OR of all channel irq requests
// Revision    : 1.0 - initial release
// ============================================================================
module checker_ctlif_mc
  import checker_ctlif_mc_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h0,
  parameter int         NCHAN    = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [13:0]           csr_a,
  input  logic                  csr_we,
  input  logic [31:0]           csr_di,
  output logic [31:0]           csr_do,
  output logic [2*NCHAN-1:0]    mode_mode,
  output logic [NCHAN-1:0]      mode_start,
  output logic [64*NCHAN-1:0]   mode_addr,
  input  logic [NCHAN-1:0]      mode_end,
  input  logic [NCHAN-1:0]      mode_error,
  input  logic [NCHAN-1:0]      mode_irq,
  output logic [NCHAN-1:0]      mode_ack,
  input  logic [64*NCHAN-1:0]   mode_data,
  output logic                  irq
);

  localparam logic [3:0] NCHAN_L    = 4'(NCHAN);
  localparam logic [7:0] NCHAN_INFO = 8'(NCHAN);

  logic        csr_sel, gbank, chan_ok, chan_we;
  logic [2:0]  chan_idx, reg_sel;
  logic [31:0] chan_rdata [8];
  logic [7:0]  pending;
  logic [31:0] rd_mux;
  logic        unused_csr_a;

  assign csr_sel  = (csr_a[13:10] == csr_addr);
  assign gbank    = csr_a[9];
  assign chan_idx = csr_a[5:3];
  assign reg_sel  = csr_a[2:0];
  assign chan_ok  = ({1'b0, chan_idx} < NCHAN_L);
  assign chan_we  = csr_we && csr_sel && !gbank && chan_ok;
  assign unused_csr_a = ^csr_a[8:6];

  // Fixed 8-slot arrays keep the channel index mux width-clean for any NCHAN.
  for (genvar i = 0; i < 8; i++) begin : g_slot
    if (i < NCHAN) begin : g_chan
      checker_ctlif_chan u_chan (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .we          (chan_we && (chan_idx == 3'(i))),
        .reg_sel     (reg_sel),
        .wdata       (csr_di),
        .hw_end      (mode_end[i]),
        .hw_error    (mode_error[i]),
        .hw_irq      (mode_irq[i]),
        .status_data (mode_data[64*i +: 64]),
        .rdata       (chan_rdata[i]),
        .mode        (mode_mode[2*i +: 2]),
        .start       (mode_start[i]),
        .addr        (mode_addr[64*i +: 64]),
        .ack         (mode_ack[i]),
        .irq_req     (pending[i])
      );
    end else begin : g_pad
      assign chan_rdata[i] = 32'd0;
      assign pending[i]    = 1'b0;
    end
  end

  assign irq = |pending;

  always_comb begin
    rd_mux = 32'd0;
    if (csr_sel) begin
      if (gbank) begin
        case (reg_sel)
          CHECKER_GCSR_PENDING: rd_mux = {24'd0, pending};
          CHECKER_GCSR_INFO:    rd_mux = {24'd0, NCHAN_INFO};
          default:              rd_mux = 32'd0;
        endcase
      end else if (chan_ok) begin
        rd_mux = chan_rdata[chan_idx];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      csr_do <= 32'd0;
    else
      csr_do <= rd_mux;
  end

endmodule : checker_ctlif_mc
`default_nettype wire
